// File: rtl/mux4x1_rr_collector.sv
// Four-source round-robin collector: merges four valid/ready sources into a single
// registered output word tagged with its source index, plus a wrapping accept counter.
module mux4x1_rr_collector #(
  parameter int BIT     = 3,
  parameter int SEL_BIT = 2   // four sources, so this must stay 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [BIT-1:0]     i0,
  input  logic [BIT-1:0]     i1,
  input  logic [BIT-1:0]     i2,
  input  logic [BIT-1:0]     i3,
  input  logic [3:0]         v,
  output logic [3:0]         rdy,
  output logic [BIT-1:0]     d,
  output logic [SEL_BIT-1:0] sel,
  output logic               d_valid,
  input  logic               d_ready,
  output logic [7:0]         cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [BIT-1:0]     r_d;
  logic [SEL_BIT-1:0] r_sel;
  logic [SEL_BIT-1:0] r_ptr;
  logic [7:0]         r_cnt;

  logic [BIT-1:0]     w_in [4];
  logic [3:0]         w_v_rot;
  logic               w_found;
  logic [SEL_BIT-1:0] w_off;
  logic [SEL_BIT-1:0] w_g;
  logic               w_load_en;
  logic               w_accept;

  assign w_in[0] = i0;
  assign w_in[1] = i1;
  assign w_in[2] = i2;
  assign w_in[3] = i3;

  // Rotate valids so bit 0 is the current round-robin head; the index wraps in SEL_BIT bits.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_rot
    assign w_v_rot[gi] = v[r_ptr + SEL_BIT'(gi)];
  end

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int j = 3; j >= 0; j--) begin
      if (w_v_rot[j]) begin
        w_found = 1'b1;
        w_off   = SEL_BIT'(j);
      end
    end
  end

  assign w_g       = r_ptr + w_off;
  assign w_load_en = en & ((r_state == EMPTY) | d_ready);
  // rst_n gating keeps every ready low while reset is asserted.
  assign w_accept  = rst_n & w_load_en & w_found;

  for (gi = 0; gi < 4; gi++) begin : g_rdy
    assign rdy[gi] = w_accept & (w_g == SEL_BIT'(gi));
  end

  always_comb begin
    w_state_next = r_state;
    if (w_accept)
      w_state_next = FULL;
    else if ((r_state == FULL) && d_ready)
      w_state_next = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d   <= '0;
      r_sel <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_d   <= w_in[w_g];
      r_sel <= w_g;
      r_ptr <= w_g + 1'b1;
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign d       = r_d;
  assign sel     = r_sel;
  assign d_valid = (r_state == FULL);
  assign cnt     = r_cnt;

endmodule

// File: doc/mux4x1_rr_collector.md
Name: mux4x1_rr_collector

Overview:
- Reverse-direction companion to the 1-to-4 block demultiplexer: merges four BIT-wide source channels into one output stream.
- Each source has a valid/ready handshake. A round-robin arbiter picks one source and registers its word into a single-entry output stage, tagged with the source index.
- Sits downstream of four producers and in front of a single consumer, such as a display or serial path.

Parameters:
- bit, 3, data width of every input and output word
- sel_bit, 2, width of the source index tag (fixed 4 sources; must be 2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  collector enable; 0 blocks new acceptances
- i0  input  bit  source 0 data
- i1  input  bit  source 1 data
- i2  input  bit  source 2 data
- i3  input  bit  source 3 data
- v  input  4  per-source valid, v[k] belongs to ik
- rdy  output  4  per-source ready, rdy[k] belongs to ik
- d  output  bit  registered output word
- sel  output  sel_bit  index of the source that produced d
- d_valid  output  1  output word valid
- d_ready  input  1  consumer ready
- cnt  output  8  total accepted words, wraps at 256

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-transfer):
  - d=0, sel=0, d_valid=0, cnt=0, round-robin pointer ptr=0.
  - rdy=0 while rst_n is low.
- Output stage states:
  - EMPTY (d_valid=0): stage holds nothing.
  - FULL (d_valid=1): stage holds one word.
- load_en = en & (~d_valid | d_ready). This is combinational; a consumer pop and a new load in the same cycle are allowed, giving full throughput of 1 word/cycle.
- Arbitration (combinational):
  - Search v[ptr], v[ptr+1], v[ptr+2], v[ptr+3], indices mod 4. The first set bit is the grant g.
  - If no v bit is set, there is no grant.
- rdy[k] = load_en & (grant exists) & (k == g). At most one rdy bit is high in any cycle. rdy does not depend on v of other channels beyond arbitration.
- Accept condition: v[g] & rdy[g] at a rising edge. On accept:
  - d <= ig, sel <= g, d_valid <= 1.
  - ptr <= (g+1) mod 4.
  - cnt <= cnt+1, wrapping 255 -> 0.
- Pop without a new accept (d_valid & d_ready, no grant or en=0): d_valid <= 0. d and sel keep their last values.
- Stall (d_valid & ~d_ready): d, sel, d_valid and ptr stay stable. rdy=0 for all sources.
- en=0:
  - No acceptances and rdy=0.
  - A word already in the stage is still presented and can be popped. The stage then empties.
  - ptr is frozen.
- Latency: one cycle from accept edge to d_valid=1.
- Sources must hold ik and v[k] stable until they see rdy[k] high at an edge. The collector does not require this for correctness; it samples only on accept.
- Fairness: a continuously-valid source waits at most 3 accepts before it is granted.

Test Plan:
- Reset mid-stream: 4 words accepted, cnt=4, then rst_n low for half a cycle → d_valid=0, d=0, sel=0, cnt=0 immediately; first accept after release comes from source 0 when v=4'b1111.
- Round-robin, all valid, d_ready=1, i0..i3=1,2,3,4 → sel sequence 0,1,2,3,0, d sequence 1,2,3,4,1; one word per cycle; cnt increments every cycle.
- Single source: only v[2] set with i2=5 → rdy=4'b0100; d=5, sel=2 one cycle later; ptr=3; next grant with v=4'b0101 goes to source 0.
- Back-pressure: d_ready=0 while FULL with d=6, sel=1 → rdy=0, d/sel/d_valid stable for 5 cycles; d_ready=1 → pop and load of next granted word in the same cycle, no bubble.
- Enable drop: en=0 while FULL with d_ready=1 → word popped, d_valid=0 next cycle, rdy stays 0, cnt unchanged; en=1 resumes from the frozen ptr.
- Counter wrap: 256 consecutive accepts → cnt returns to 0 and keeps counting.
